imm_gen_pipe: RTL and testbench

- Pipelined, parametrised immediate generator for the RISC-V datapath.
- Accepts a full 32-bit instruction word and extracts the immediate. The immediate type comes either from an explicit selector or from internal opcode decode.
- Sign-extends the immediate to XLEN and delivers it through a registered valid/ready stage with a 2-entry skid buffer.
- Sits between instruction fetch/decode and the operand stage of the pipelined core; carries a sideband tag, e.g. the PC.

---
 rtl/imm_gen_pipe.sv | 160 ++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with a 2-entry (output + skid) valid/ready stage.
// Define IMM_GEN_PIPE_ZIMM_EN to add the CSR*I zero-extended Z immediate (type 101).
module imm_gen_pipe #(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b1,
    parameter int TAG_W       = 32,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100,
        IMM_Z = 3'b101
    } imm_type_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } entry_t;

    imm_type_e   w_type;
    logic        w_type_ok;
    logic [31:0] w_raw32;
    entry_t      w_new;

    entry_t r_out;
    entry_t r_skid;
    logic   r_out_valid;
    logic   r_skid_valid;
    logic   r_in_ready;
    logic [CNT_W-1:0] r_cnt;

    logic w_in_fire;
    logic w_out_fire;
    logic w_out_free;
    logic w_skid_nxt;

    // Immediate type: opcode decode or explicit selector, plus a legality flag.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_type    = IMM_I;
        w_type_ok = 1'b1;
        if (AUTO_DECODE) begin
            case (in_inst[6:0])
                7'b0010011, 7'b0000011, 7'b1100111: w_type = IMM_I;
                7'b0011011:                         w_type_ok = (XLEN == 64);
                7'b0100011:                         w_type = IMM_S;
                7'b1100011:                         w_type = IMM_B;
                7'b0110111, 7'b0010111:             w_type = IMM_U;
                7'b1101111:                         w_type = IMM_J;
`ifdef IMM_GEN_PIPE_ZIMM_EN
                7'b1110011: w_type = in_inst[14] ? IMM_Z : IMM_I;
`else
                7'b1110011: w_type = IMM_I;
`endif
                default:    w_type_ok = 1'b0;
            endcase
        end else begin
            case (in_src)
                3'b000: w_type = IMM_I;
                3'b001: w_type = IMM_S;
                3'b010: w_type = IMM_B;
                3'b011: w_type = IMM_U;
                3'b100: w_type = IMM_J;
`ifdef IMM_GEN_PIPE_ZIMM_EN
                3'b101: w_type = IMM_Z;
`endif
                default: w_type_ok = 1'b0;
            endcase
        end
    end

    // Build a 32-bit signed immediate, then sign-extend it to XLEN.
    always_comb begin
        w_raw32 = 32'b0;
        case (w_type)
            IMM_I: w_raw32 = {{20{in_inst[31]}}, in_inst[31:20]};
            IMM_S: w_raw32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            IMM_B: w_raw32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                              in_inst[30:25], in_inst[11:8], 1'b0};
            IMM_U: w_raw32 = {in_inst[31:12], 12'b0};
            IMM_J: w_raw32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                              in_inst[20], in_inst[30:21], 1'b0};
            default: w_raw32 = 32'b0;
        endcase

        w_new.imm = XLEN'($signed(w_raw32));
        if (w_type == IMM_Z)
            w_new.imm = XLEN'(in_inst[19:15]);
        if (!w_type_ok)
            w_new.imm = '0;
        w_new.tag = in_tag;
        w_new.ill = !w_type_ok;
    end

    assign w_in_fire  = in_valid && r_in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_out_free = !r_out_valid || out_ready;
    // The skid only fills when the output is held; any free output slot drains it.
    assign w_skid_nxt = w_out_free ? 1'b0 : (r_skid_valid || w_in_fire);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
            r_cnt        <= '0;
        end else begin
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out       <= r_skid;
                    r_out_valid <= 1'b1;
                end else if (w_in_fire) begin
                    r_out       <= w_new;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
            r_skid_valid <= w_skid_nxt;
            r_in_ready   <= !w_skid_nxt;
            if (w_out_fire && r_out.ill && (r_cnt != '1))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // NOTE: skid payload needs no reset; r_skid_valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (!w_out_free && !r_skid_valid && w_in_fire)
            r_skid <= w_new;
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_imm     = r_out.imm;
    assign out_tag     = r_out.tag;
    assign out_illegal = r_out.ill;
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: a 32-bit auto-decode instance and a 64-bit explicit-select
// instance with a 2-bit counter; expectations follow IMM_GEN_PIPE_ZIMM_EN when it is defined.
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [31:0] tag;
        logic        ill;
    } exp_t;

`ifdef IMM_GEN_PIPE_ZIMM_EN
    localparam logic [63:0] CSR_AUTO_IMM = 64'h0000_0000_0000_000F;
    localparam logic [63:0] CSR_EXPL_IMM = 64'h0000_0000_0000_000F;
    localparam logic        CSR_EXPL_ILL = 1'b0;
`else
    localparam logic [63:0] CSR_AUTO_IMM = 64'h0;
    localparam logic [63:0] CSR_EXPL_IMM = 64'h0;
    localparam logic        CSR_EXPL_ILL = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b1, out_illegal0;
    logic [31:0] in_inst0 = '0, in_tag0 = '0, out_imm0, out_tag0;
    logic [2:0]  in_src0 = '0;
    logic [15:0] cnt0;

    logic        in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1, out_illegal1;
    logic [31:0] in_inst1 = '0, in_tag1 = '0, out_tag1;
    logic [63:0] out_imm1;
    logic [2:0]  in_src1 = '0;
    logic [1:0]  cnt1;

    exp_t q0[$];
    exp_t q1[$];
    int n_checks = 0;
    int n_fail   = 0;

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1), .TAG_W(32), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_inst(in_inst0), .in_src(in_src0),
        .in_tag(in_tag0), .out_valid(out_valid0), .out_ready(out_ready0), .out_imm(out_imm0),
        .out_tag(out_tag0), .out_illegal(out_illegal0), .illegal_cnt(cnt0)
    );

    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b0), .TAG_W(32), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_inst(in_inst1), .in_src(in_src1),
        .in_tag(in_tag1), .out_valid(out_valid1), .out_ready(out_ready1), .out_imm(out_imm1),
        .out_tag(out_tag1), .out_illegal(out_illegal1), .illegal_cnt(cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: sample mid low-phase, after the driver has settled its inputs.
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid0 && out_ready0) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut0_unexpected_output: got imm 0x%0h tag 0x%0h, expected none", out_imm0, out_tag0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("dut0_imm", {32'b0, out_imm0}, e.imm);
                check("dut0_tag", {32'b0, out_tag0}, {32'b0, e.tag});
                check("dut0_illegal", {63'b0, out_illegal0}, {63'b0, e.ill});
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut1_unexpected_output: got imm 0x%0h tag 0x%0h, expected none", out_imm1, out_tag1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dut1_imm", out_imm1, e.imm);
                check("dut1_tag", {32'b0, out_tag1}, {32'b0, e.tag});
                check("dut1_illegal", {63'b0, out_illegal1}, {63'b0, e.ill});
            end
        end
    end

    task automatic send0(input logic [31:0] inst, input logic [31:0] tag,
                         input logic [63:0] imm, input logic ill);
        int n = 0;
        @(negedge clk);
        in_valid0 = 1'b1;
        in_inst0  = inst;
        in_tag0   = tag;
        while (!in_ready0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready0) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut0_send_timeout: got in_ready 0 for tag 0x%0h, expected 1", tag);
        end else begin
            q0.push_back('{imm: imm, tag: tag, ill: ill});
            @(posedge clk);
        end
    endtask

    task automatic send1(input logic [31:0] inst, input logic [2:0] src, input logic [31:0] tag,
                         input logic [63:0] imm, input logic ill);
        int n = 0;
        @(negedge clk);
        in_valid1 = 1'b1;
        in_inst1  = inst;
        in_src1   = src;
        in_tag1   = tag;
        while (!in_ready1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready1) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut1_send_timeout: got in_ready 0 for tag 0x%0h, expected 1", tag);
        end else begin
            q1.push_back('{imm: imm, tag: tag, ill: ill});
            @(posedge clk);
        end
    endtask

    task automatic drain(input int which);
        int n = 0;
        @(negedge clk);
        in_valid0 = (which == 0) ? 1'b0 : in_valid0;
        in_valid1 = (which == 1) ? 1'b0 : in_valid1;
        while (((which == 0) ? q0.size() : q1.size()) != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check((which == 0) ? "dut0_drain_left" : "dut1_drain_left",
              64'((which == 0) ? q0.size() : q1.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", {63'b0, out_valid0}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready0}, 64'd0);
        check("rst_out_imm", {32'b0, out_imm0}, 64'd0);
        check("rst_out_tag", {32'b0, out_tag0}, 64'd0);
        check("rst_out_illegal", {63'b0, out_illegal0}, 64'd0);
        check("rst_cnt", {48'b0, cnt0}, 64'd0);
        check("rst_out_valid1", {63'b0, out_valid1}, 64'd0);
        repeat (2) @(negedge clk);
        check("rst_held_in_ready", {63'b0, in_ready0}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {63'b0, in_ready0}, 64'd1);

        // Single I-type, then back-to-back S/B/U/J
        send0(32'hFFF0_0093, 32'h100, 64'hFFFF_FFFF, 1'b0);
        send0(32'hFE11_2E23, 32'h101, 64'hFFFF_FFFC, 1'b0);
        send0(32'hFE00_0CE3, 32'h102, 64'hFFFF_FFF8, 1'b0);
        send0(32'h1234_50B7, 32'h103, 64'h1234_5000, 1'b0);
        send0(32'h0010_006F, 32'h104, 64'h0000_0800, 1'b0);
        send0(32'h0007_D073, 32'h105, CSR_AUTO_IMM, 1'b0);
        drain(0);
        check("cnt0_no_illegal", {48'b0, cnt0}, 64'd0);

        // Illegal opcodes: unknown, and OP-IMM-32 on a 32-bit build
        send0(32'h0000_007F, 32'h200, 64'd0, 1'b1);
        drain(0);
        check("cnt0_after_one", {48'b0, cnt0}, 64'd1);
        send0(32'h0000_001B, 32'h201, 64'd0, 1'b1);
        drain(0);
        check("cnt0_after_two", {48'b0, cnt0}, 64'd2);

        // Backpressure: two accepted, third held until the consumer resumes
        @(negedge clk);
        out_ready0 = 1'b0;
        send0(32'h0050_0093, 32'h300, 64'h0000_0005, 1'b0);
        send0(32'h8000_0037, 32'h301, 64'h8000_0000, 1'b0);
        @(negedge clk);
        in_valid0 = 1'b0;
        check("bp_in_ready_low", {63'b0, in_ready0}, 64'd0);
        check("bp_hold_imm", {32'b0, out_imm0}, 64'h0000_0005);
        fork
            send0(32'h7FF0_0113, 32'h302, 64'h0000_07FF, 1'b0);
            begin
                repeat (3) @(negedge clk);
                check("bp_still_blocked", {63'b0, in_ready0}, 64'd0);
                check("bp_still_hold_tag", {32'b0, out_tag0}, 64'h300);
                out_ready0 = 1'b1;
            end
        join
        drain(0);

        // 64-bit explicit-select instance
        send1(32'h8000_00B7, 3'b011, 32'h400, 64'hFFFF_FFFF_8000_0000, 1'b0);
        send1(32'hFFF0_0093, 3'b000, 32'h401, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send1(32'hFE11_2E23, 3'b001, 32'h402, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        send1(32'hFE00_0CE3, 3'b010, 32'h403, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        send1(32'h0010_006F, 3'b100, 32'h404, 64'h0000_0000_0000_0800, 1'b0);
        drain(1);
        check("cnt1_no_illegal", {62'b0, cnt1}, 64'd0);
        send1(32'h0000_0013, 3'b111, 32'h410, 64'd0, 1'b1);
        drain(1);
        check("cnt1_after_one", {62'b0, cnt1}, 64'd1);
        send1(32'h0000_0013, 3'b110, 32'h411, 64'd0, 1'b1);
        send1(32'h0000_0013, 3'b111, 32'h412, 64'd0, 1'b1);
        send1(32'h0000_0013, 3'b110, 32'h413, 64'd0, 1'b1);
        send1(32'h0000_0013, 3'b111, 32'h414, 64'd0, 1'b1);
        drain(1);
        check("cnt1_saturated", {62'b0, cnt1}, 64'd3);
        send1(32'h0007_D073, 3'b101, 32'h420, CSR_EXPL_IMM, CSR_EXPL_ILL);
        drain(1);
        check("cnt1_still_saturated", {62'b0, cnt1}, 64'd3);

        // Reset with both entries full: everything buffered is discarded
        @(negedge clk);
        out_ready0 = 1'b0;
        send0(32'h0010_0093, 32'h500, 64'h1, 1'b0);
        send0(32'h0020_0093, 32'h501, 64'h2, 1'b0);
        @(negedge clk);
        in_valid0 = 1'b0;
        check("full_in_ready", {63'b0, in_ready0}, 64'd0);
        check("full_out_valid", {63'b0, out_valid0}, 64'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", {63'b0, out_valid0}, 64'd0);
        check("midrst_in_ready", {63'b0, in_ready0}, 64'd0);
        check("midrst_out_imm", {32'b0, out_imm0}, 64'd0);
        check("midrst_cnt", {48'b0, cnt0}, 64'd0);
        q0.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready0 = 1'b1;
        repeat (5) @(negedge clk);
        check("post_midrst_out_valid", {63'b0, out_valid0}, 64'd0);
        check("post_midrst_in_ready", {63'b0, in_ready0}, 64'd1);

        check("final_q0_empty", 64'(q0.size()), 64'd0);
        check("final_q1_empty", 64'(q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
